// File: rtl/control_botones_config.sv
// Button front-end: synchronizes and debounces five push-buttons, produces gated
// one-cycle direction pulses with UP/DOWN auto-repeat, and sequences config_mode.
module control_botones_config #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 50000000,
  parameter int REP_PERIOD = 15000000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_mode,
  output logic       enUP,
  output logic       enDOWN,
  output logic       enLEFT,
  output logic       enRIGHT,
  output logic [2:0] config_mode,
  output logic       config_active
);

  localparam int NB = 5;
  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LF = 2;
  localparam int RT = 3;
  localparam int MD = 4;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    HORA   = 3'd1,
    FECHA  = 3'd2,
    TIMER  = 3'd4
  } mode_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    deb;
  logic [NB-1:0]    deb_q;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] deb_cnt [NB];

  logic [CNT_W-1:0] rep_cnt [2];
  logic [1:0]       rep_started;
  logic [1:0]       rep_fire;

  logic  hold_conflict;
  logic  dir_ok;
  logic  mode_ev;
  mode_t state;

  assign raw           = {btn_mode, btn_right, btn_left, btn_down, btn_up};
  assign hold_conflict = deb_q[UP] & deb_q[DN];
  assign dir_ok        = (state != NORMAL) && !press[MD];
  assign config_mode   = state;

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= ~deb[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Repeat counters restart from zero on release or while UP and DOWN are both held
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_started <= '0;
      rep_fire    <= '0;
      for (int i = 0; i < 2; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_fire[i] <= 1'b0;
        if (!(deb[i] && deb_q[i]) || hold_conflict) begin
          rep_cnt[i]     <= '0;
          rep_started[i] <= 1'b0;
        end else if (rep_cnt[i] == (rep_started[i] ? PERIOD_LAST : DELAY_LAST)) begin
          rep_cnt[i]     <= '0;
          rep_started[i] <= 1'b1;
          rep_fire[i]    <= 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Output pulses and mode FSM; a mode event in the same cycle swallows direction pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      enUP          <= 1'b0;
      enDOWN        <= 1'b0;
      enLEFT        <= 1'b0;
      enRIGHT       <= 1'b0;
      mode_ev       <= 1'b0;
      state         <= NORMAL;
      config_active <= 1'b0;
    end else begin
      enUP    <= dir_ok && !hold_conflict && (press[UP] || rep_fire[UP]);
      enDOWN  <= dir_ok && !hold_conflict && (press[DN] || rep_fire[DN]);
      enLEFT  <= dir_ok && press[LF] && !press[RT];
      enRIGHT <= dir_ok && press[RT] && !press[LF];
      mode_ev <= press[MD];
      if (mode_ev) begin
        case (state)
          NORMAL: begin
            state         <= HORA;
            config_active <= 1'b1;
          end
          HORA: begin
            state         <= FECHA;
            config_active <= 1'b1;
          end
          FECHA: begin
            state         <= TIMER;
            config_active <= 1'b1;
          end
          default: begin
            state         <= NORMAL;
            config_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_botones_config.sv
// Self-checking bench for control_botones_config: expected pulses (cycle, output id)
// are queued when a button is driven and matched against pulses the DUT emits.
module tb_control_botones_config;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_mode = 1'b0;
  logic       enUP;
  logic       enDOWN;
  logic       enLEFT;
  logic       enRIGHT;
  logic [2:0] config_mode;
  logic       config_active;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int c;
    int id;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  control_botones_config #(
    .DEB_CYCLES(4),
    .REP_DELAY (20),
    .REP_PERIOD(8),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_mode     (btn_mode),
    .enUP         (enUP),
    .enDOWN       (enDOWN),
    .enLEFT       (enLEFT),
    .enRIGHT      (enRIGHT),
    .config_mode  (config_mode),
    .config_active(config_active)
  );

  always #5 clk = ~clk;

  // cyc names the most recent rising edge; pulses are logged with it on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enUP)    obs_q.push_back('{cyc, 0});
    if (enDOWN)  obs_q.push_back('{cyc, 1});
    if (enLEFT)  obs_q.push_back('{cyc, 2});
    if (enRIGHT) obs_q.push_back('{cyc, 3});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic advance_mode();
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({enUP, enDOWN, enLEFT, enRIGHT} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_pulses: got %b, expected 0000", {enUP, enDOWN, enLEFT, enRIGHT});
    end
    checks++;
    if (config_mode !== 3'd0 || config_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mode: got mode=%0d active=%0d, expected 0/0", config_mode, config_active);
    end
  endtask

  task automatic test_mode_cycle();
    logic [2:0] seq [4];
    logic [2:0] prev;
    int t0;
    seq[0] = 3'd1; seq[1] = 3'd2; seq[2] = 3'd4; seq[3] = 3'd0;
    prev = 3'd0;
    obs_q.delete();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t0 = cyc + 1;
      btn_mode = 1'b1;
      wait_cyc(t0 + 7);
      checks++;
      if (config_mode !== prev) begin
        errors++;
        $display("[TB] FAIL mode_early_%0d: got %0d, expected %0d", k, config_mode, prev);
      end
      wait_cyc(t0 + 8);
      checks++;
      if (config_mode !== seq[k]) begin
        errors++;
        $display("[TB] FAIL mode_step_%0d: got %0d, expected %0d", k, config_mode, seq[k]);
      end
      checks++;
      if (config_active !== (seq[k] != 3'd0)) begin
        errors++;
        $display("[TB] FAIL active_step_%0d: got %0d, expected %0d", k, config_active, seq[k] != 3'd0);
      end
      wait_cyc(t0 + 9);
      btn_mode = 1'b0;
      wait_cyc(t0 + 19);
      prev = seq[k];
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mode_no_dir: got %0d direction pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_gating_mode0();
    int t0;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_up = 1'b1;
    btn_right = 1'b1;
    wait_cyc(t0 + 39);
    btn_up = 1'b0;
    btn_right = 1'b0;
    wait_cyc(t0 + 60);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mode0_gate: got %0d pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_repeat();
    ev_t e;
    ev_t o;
    int t0;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_up = 1'b1;
    exp_q.push_back('{t0 + 7, 0});
    for (int k = 0; k < 5; k++) exp_q.push_back('{t0 + 27 + 8 * k, 0});
    wait_cyc(t0 + 59);
    btn_up = 1'b0;
    wait_cyc(t0 + 90);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL repeat_pulse: got none, expected id=%0d at cycle %0d", e.id, e.c - t0);
      end else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.id !== e.id) begin
          errors++;
          $display("[TB] FAIL repeat_pulse: got id=%0d at %0d, expected id=%0d at %0d", o.id, o.c - t0, e.id, e.c - t0);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL repeat_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_bounce();
    ev_t e;
    ev_t o;
    int t0;
    int s;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_left = 1'b1;
    wait_cyc(t0 + 2);
    btn_left = 1'b0;
    wait_cyc(t0 + 5);
    btn_left = 1'b1;
    wait_cyc(t0 + 8);
    btn_left = 1'b0;
    wait_cyc(t0 + 11);
    btn_left = 1'b1;
    s = t0 + 12;
    exp_q.push_back('{s + 7, 2});
    wait_cyc(s + 29);
    btn_left = 1'b0;
    wait_cyc(s + 45);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL bounce_pulse: got none, expected id=%0d at %0d", e.id, e.c - s);
      end else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.id !== e.id) begin
          errors++;
          $display("[TB] FAIL bounce_pulse: got id=%0d at %0d, expected id=%0d at %0d", o.id, o.c - s, e.id, e.c - s);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bounce_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_mode_wins();
    int t0;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_mode = 1'b1;
    btn_right = 1'b1;
    wait_cyc(t0 + 7);
    checks++;
    if (config_mode !== 3'd1) begin
      errors++;
      $display("[TB] FAIL modewin_old: got %0d, expected 1", config_mode);
    end
    wait_cyc(t0 + 8);
    checks++;
    if (config_mode !== 3'd2) begin
      errors++;
      $display("[TB] FAIL modewin_new: got %0d, expected 2", config_mode);
    end
    wait_cyc(t0 + 9);
    btn_mode = 1'b0;
    btn_right = 1'b0;
    wait_cyc(t0 + 30);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL modewin_right: got %0d pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_conflict();
    ev_t e;
    ev_t o;
    int t0;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_up = 1'b1;
    exp_q.push_back('{t0 + 7, 0});
    wait_cyc(t0 + 14);
    btn_down = 1'b1;
    wait_cyc(t0 + 39);
    btn_down = 1'b0;
    // DOWN release seen at t0+40, debounced 5 later, then a fresh REP_DELAY before enUP
    exp_q.push_back('{t0 + 67, 0});
    wait_cyc(t0 + 67);
    btn_up = 1'b0;
    wait_cyc(t0 + 100);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL conflict_pulse: got none, expected id=%0d at %0d", e.id, e.c - t0);
      end else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.id !== e.id) begin
          errors++;
          $display("[TB] FAIL conflict_pulse: got id=%0d at %0d, expected id=%0d at %0d", o.id, o.c - t0, e.id, e.c - t0);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL conflict_extra: got %0d extra pulses, expected 0", obs_q.size());
    end
  endtask

  task automatic test_reset_hold();
    ev_t e;
    ev_t o;
    int t0;
    obs_q.delete();
    @(negedge clk);
    t0 = cyc + 1;
    btn_down = 1'b1;
    exp_q.push_back('{t0 + 7, 1});
    wait_cyc(t0 + 9);
    reset = 1'b1;
    wait_cyc(t0 + 10);
    reset = 1'b0;
    checks++;
    if (config_mode !== 3'd0 || config_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsthold_mode: got mode=%0d active=%0d, expected 0/0", config_mode, config_active);
    end
    wait_cyc(t0 + 50);
    btn_down = 1'b0;
    wait_cyc(t0 + 60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rsthold_pulse: got none, expected id=%0d at %0d", e.id, e.c - t0);
      end else begin
        o = obs_q.pop_front();
        if (o.c !== e.c || o.id !== e.id) begin
          errors++;
          $display("[TB] FAIL rsthold_pulse: got id=%0d at %0d, expected id=%0d at %0d", o.id, o.c - t0, e.id, e.c - t0);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rsthold_extra: got %0d pulses after reset, expected 0", obs_q.size());
    end
    checks++;
    if (config_mode !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rsthold_final: got mode=%0d, expected 0", config_mode);
    end
  endtask

  initial begin
    $display("[TB] starting control_botones_config bench");
    test_reset();
    test_mode_cycle();
    test_gating_mode0();
    advance_mode();
    test_repeat();
    test_bounce();
    test_mode_wins();
    test_conflict();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
